// File: rtl/fsm_prob_b_driver.sv
// fsm_prob_b_driver
// Drives the i/j inputs of an fsm_prob_b instance so that it reaches a
// requested goal state. The driver tracks its own copy of the controlled FSM
// and compares the observed x/y outputs against the expected outputs.
module fsm_prob_b_driver #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       goal_valid,
    input  logic [1:0] goal,
    output logic       goal_ready,
    output logic       i,
    output logic       j,
    input  logic       x,
    input  logic       y,
    output logic       done,
    output logic [1:0] steps,
    output logic       mismatch,
    output logic [1:0] model_state
);

    // States of the controlled FSM, encoded as seen on the goal input.
    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } fsmState_t;

    // Driver phase: waiting for a goal, or steering toward one.
    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_RUN  = 1'b1
    } phase_t;

    // Transition function of the controlled FSM.
    function automatic fsmState_t nextState(input fsmState_t s,
                                            input logic ii,
                                            input logic jj);
        fsmState_t n;
        n = s;
        case (s)
            ST_A:    n = ii ? ST_B : ST_A;
            ST_B:    n = ii ? ST_C : ST_D;
            ST_C:    n = ii ? ST_B : (jj ? ST_C : ST_D);
            ST_D:    n = ii ? ST_D : (jj ? ST_C : ST_A);
            default: n = ST_A;
        endcase
        return n;
    endfunction

    // Expected {x,y} of the controlled FSM in each state.
    function automatic logic [1:0] expectedXy(input fsmState_t s);
        logic [1:0] o;
        o = 2'b11;
        case (s)
            ST_A:    o = 2'b11;
            ST_B:    o = 2'b01;
            ST_C:    o = 2'b10;
            ST_D:    o = 2'b10;
            default: o = 2'b11;
        endcase
        return o;
    endfunction

    // {i,j} that moves the FSM one transition closer to the target.
    // Every pair here is a real transition, so each RUN edge counts as one step.
    function automatic logic [1:0] stepIj(input fsmState_t s,
                                          input fsmState_t target);
        logic [1:0] o;
        o = 2'b00;
        case (s)
            ST_A:    o = 2'b10;
            ST_B:    o = (target == ST_C) ? 2'b10 : 2'b00;
            ST_C:    o = (target == ST_B) ? 2'b10 : 2'b00;
            ST_D:    o = (target == ST_A) ? 2'b00 : 2'b01;
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    // {i,j} that keeps the FSM where it is; B has no self loop and drifts to D.
    function automatic logic [1:0] holdIj(input fsmState_t s);
        logic [1:0] o;
        o = 2'b00;
        case (s)
            ST_A:    o = 2'b00;
            ST_B:    o = 2'b00;
            ST_C:    o = 2'b01;
            ST_D:    o = 2'b10;
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    phase_t     r_phase;
    fsmState_t  r_modelState;
    fsmState_t  r_goal;
    logic       r_i;
    logic       r_j;
    logic       r_done;
    logic [1:0] r_steps;
    logic [1:0] r_count;
    logic       r_mismatch;

    phase_t     w_phaseNext;
    fsmState_t  w_nm;
    fsmState_t  w_goalIn;
    fsmState_t  w_goalNext;
    logic [1:0] w_ijNext;
    logic       w_doneNext;
    logic [1:0] w_stepsNext;
    logic [1:0] w_countNext;
    logic       w_mismatchNext;
    logic       w_xyBad;

    // State register: every piece of driver state, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase      <= PH_IDLE;
            r_modelState <= ST_A;
            r_goal       <= ST_A;
            r_i          <= 1'b0;
            r_j          <= 1'b0;
            r_done       <= 1'b0;
            r_steps      <= 2'd0;
            r_count      <= 2'd0;
            r_mismatch   <= 1'b0;
        end else begin
            r_phase      <= w_phaseNext;
            r_modelState <= w_nm;
            r_goal       <= w_goalNext;
            r_i          <= w_ijNext[1];
            r_j          <= w_ijNext[0];
            r_done       <= w_doneNext;
            r_steps      <= w_stepsNext;
            r_count      <= w_countNext;
            r_mismatch   <= w_mismatchNext;
        end
    end

    // Next-state logic: advance the model, pick the next stimulus from the
    // model's next state, and handle goal acceptance and completion.
    always_comb begin
        w_nm           = nextState(r_modelState, r_i, r_j);
        w_goalIn       = fsmState_t'(goal);
        w_phaseNext    = r_phase;
        w_goalNext     = r_goal;
        w_ijNext       = holdIj(w_nm);
        w_doneNext     = 1'b0;
        w_stepsNext    = r_steps;
        w_countNext    = r_count;
        w_xyBad        = CHECK_EN && ({x, y} != expectedXy(r_modelState));
        w_mismatchNext = r_mismatch | w_xyBad;

        case (r_phase)
            PH_IDLE: begin
                if (goal_valid) begin
                    w_goalNext  = w_goalIn;
                    w_countNext = 2'd0;
                    if (w_nm == w_goalIn) begin
                        w_doneNext  = 1'b1;
                        w_stepsNext = 2'd0;
                    end else begin
                        w_phaseNext = PH_RUN;
                        w_ijNext    = stepIj(w_nm, w_goalIn);
                    end
                end
            end
            PH_RUN: begin
                if (w_nm == r_goal) begin
                    w_phaseNext = PH_IDLE;
                    w_doneNext  = 1'b1;
                    w_stepsNext = r_count + 2'd1;
                end else begin
                    w_ijNext    = stepIj(w_nm, r_goal);
                    w_countNext = r_count + 2'd1;
                end
            end
            default: begin
                w_phaseNext = PH_IDLE;
            end
        endcase
    end

    assign goal_ready  = (r_phase == PH_IDLE);
    assign i           = r_i;
    assign j           = r_j;
    assign done        = r_done;
    assign steps       = r_steps;
    assign mismatch    = r_mismatch;
    assign model_state = r_modelState;

endmodule

// File: tb/tb_fsm_prob_b_driver.sv
// tb_fsm_prob_b_driver
// Directed bench: a behavioural fsm_prob_b plant is driven by the DUT, and
// each scenario task checks hand-computed values at falling edges.
module tb_fsm_prob_b_driver;

    logic       clk;
    logic       rstn;
    logic       goalValid;
    logic [1:0] goal;
    logic       goalReady;
    logic       dutI;
    logic       dutJ;
    logic       x;
    logic       y;
    logic       done;
    logic [1:0] steps;
    logic       mismatch;
    logic [1:0] modelState;

    logic [1:0] plantState;
    logic       forceXy;

    int checkCount;
    int passCount;

    fsm_prob_b_driver #(.CHECK_EN(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .goal_valid (goalValid),
        .goal       (goal),
        .goal_ready (goalReady),
        .i          (dutI),
        .j          (dutJ),
        .x          (x),
        .y          (y),
        .done       (done),
        .steps      (steps),
        .mismatch   (mismatch),
        .model_state(modelState)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The controlled fsm_prob_b: same reset net, stimulated by the DUT.
    always @(posedge clk) begin
        if (!rstn) plantState <= 2'd0;
        else begin
            case (plantState)
                2'd0: plantState <= dutI ? 2'd1 : 2'd0;
                2'd1: plantState <= dutI ? 2'd2 : 2'd3;
                2'd2: plantState <= dutI ? 2'd1 : (dutJ ? 2'd2 : 2'd3);
                default: plantState <= dutI ? 2'd3 : (dutJ ? 2'd2 : 2'd0);
            endcase
        end
    end

    // Plant outputs, optionally forced low to provoke the checker.
    always_comb begin
        {x, y} = 2'b11;
        if (forceXy) {x, y} = 2'b00;
        else begin
            case (plantState)
                2'd0: {x, y} = 2'b11;
                2'd1: {x, y} = 2'b01;
                default: {x, y} = 2'b10;
            endcase
        end
    end

    task automatic test_reset();
        rstn = 1'b0; goalValid = 1'b0; goal = 2'd0; forceXy = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        checkCount++; if (goalReady !== 1'b1) $display("[TB] FAIL rst_ready got %0b exp 1", goalReady); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL rst_done got %0b exp 0", done); else passCount++;
        checkCount++; if (steps !== 2'd0) $display("[TB] FAIL rst_steps got %0d exp 0", steps); else passCount++;
        checkCount++; if (mismatch !== 1'b0) $display("[TB] FAIL rst_mismatch got %0b exp 0", mismatch); else passCount++;
        checkCount++; if (modelState !== 2'd0) $display("[TB] FAIL rst_model got %0d exp 0", modelState); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b00) $display("[TB] FAIL rst_ij got %b exp 00", {dutI, dutJ}); else passCount++;
        @(negedge clk);
        checkCount++; if (modelState !== 2'd0) $display("[TB] FAIL rst_idle_model got %0d exp 0", modelState); else passCount++;
    endtask

    task automatic test_goal_c();
        goalValid = 1'b1; goal = 2'd2;
        @(negedge clk);
        goalValid = 1'b0;
        checkCount++; if ({dutI, dutJ} !== 2'b10) $display("[TB] FAIL c_e0_ij got %b exp 10", {dutI, dutJ}); else passCount++;
        checkCount++; if (goalReady !== 1'b0) $display("[TB] FAIL c_e0_ready got %0b exp 0", goalReady); else passCount++;
        @(negedge clk);
        checkCount++; if ({dutI, dutJ} !== 2'b10) $display("[TB] FAIL c_e1_ij got %b exp 10", {dutI, dutJ}); else passCount++;
        checkCount++; if ({x, y} !== 2'b01) $display("[TB] FAIL c_e1_xy got %b exp 01", {x, y}); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL c_e1_done got %0b exp 0", done); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL c_done got %0b exp 1", done); else passCount++;
        checkCount++; if (goalReady !== 1'b1) $display("[TB] FAIL c_ready got %0b exp 1", goalReady); else passCount++;
        checkCount++; if (steps !== 2'd2) $display("[TB] FAIL c_steps got %0d exp 2", steps); else passCount++;
        checkCount++; if ({x, y} !== 2'b10) $display("[TB] FAIL c_xy got %b exp 10", {x, y}); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b01) $display("[TB] FAIL c_hold_ij got %b exp 01", {dutI, dutJ}); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL c_done_pulse got %0b exp 0", done); else passCount++;
        checkCount++; if (modelState !== 2'd2) $display("[TB] FAIL c_model got %0d exp 2", modelState); else passCount++;
        checkCount++; if (mismatch !== 1'b0) $display("[TB] FAIL c_mismatch got %0b exp 0", mismatch); else passCount++;
    endtask

    task automatic test_goal_a_from_c();
        goalValid = 1'b1; goal = 2'd0;
        @(negedge clk);
        goal = 2'd3;
        checkCount++; if ({dutI, dutJ} !== 2'b00) $display("[TB] FAIL ca_e0_ij got %b exp 00", {dutI, dutJ}); else passCount++;
        @(negedge clk);
        goalValid = 1'b0;
        checkCount++; if (modelState !== 2'd3) $display("[TB] FAIL ca_e1_model got %0d exp 3", modelState); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b00) $display("[TB] FAIL ca_e1_ij got %b exp 00", {dutI, dutJ}); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL ca_e1_done got %0b exp 0", done); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL ca_done got %0b exp 1", done); else passCount++;
        checkCount++; if (steps !== 2'd2) $display("[TB] FAIL ca_steps got %0d exp 2", steps); else passCount++;
        checkCount++; if ({x, y} !== 2'b11) $display("[TB] FAIL ca_xy got %b exp 11", {x, y}); else passCount++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkCount++; if (modelState !== 2'd0) $display("[TB] FAIL ca_stay_model%0d got %0d exp 0", k, modelState); else passCount++;
            checkCount++; if ({x, y} !== 2'b11) $display("[TB] FAIL ca_stay_xy%0d got %b exp 11", k, {x, y}); else passCount++;
            checkCount++; if ({dutI, dutJ} !== 2'b00) $display("[TB] FAIL ca_stay_ij%0d got %b exp 00", k, {dutI, dutJ}); else passCount++;
        end
    endtask

    task automatic test_goal_b();
        goalValid = 1'b1; goal = 2'd1;
        @(negedge clk);
        goalValid = 1'b0;
        checkCount++; if ({dutI, dutJ} !== 2'b10) $display("[TB] FAIL b_e0_ij got %b exp 10", {dutI, dutJ}); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL b_done got %0b exp 1", done); else passCount++;
        checkCount++; if (steps !== 2'd1) $display("[TB] FAIL b_steps got %0d exp 1", steps); else passCount++;
        checkCount++; if (modelState !== 2'd1) $display("[TB] FAIL b_model got %0d exp 1", modelState); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b00) $display("[TB] FAIL b_ij got %b exp 00", {dutI, dutJ}); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL b_done_pulse got %0b exp 0", done); else passCount++;
        checkCount++; if (modelState !== 2'd3) $display("[TB] FAIL b_drift_model got %0d exp 3", modelState); else passCount++;
        checkCount++; if ({x, y} !== 2'b10) $display("[TB] FAIL b_drift_xy got %b exp 10", {x, y}); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b10) $display("[TB] FAIL b_hold_d_ij got %b exp 10", {dutI, dutJ}); else passCount++;
        checkCount++; if (mismatch !== 1'b0) $display("[TB] FAIL b_mismatch got %0b exp 0", mismatch); else passCount++;
    endtask

    task automatic test_goal_same();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        goalValid = 1'b1; goal = 2'd0;
        @(negedge clk);
        goalValid = 1'b0;
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL same_done got %0b exp 1", done); else passCount++;
        checkCount++; if (steps !== 2'd0) $display("[TB] FAIL same_steps got %0d exp 0", steps); else passCount++;
        checkCount++; if (goalReady !== 1'b1) $display("[TB] FAIL same_ready got %0b exp 1", goalReady); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b00) $display("[TB] FAIL same_ij got %b exp 00", {dutI, dutJ}); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL same_pulse got %0b exp 0", done); else passCount++;
    endtask

    task automatic test_mismatch();
        goalValid = 1'b1; goal = 2'd2;
        @(negedge clk);
        goalValid = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++; if (modelState !== 2'd2) $display("[TB] FAIL mm_pre_model got %0d exp 2", modelState); else passCount++;
        checkCount++; if (mismatch !== 1'b0) $display("[TB] FAIL mm_pre got %0b exp 0", mismatch); else passCount++;
        forceXy = 1'b1;
        @(negedge clk);
        forceXy = 1'b0;
        checkCount++; if (mismatch !== 1'b1) $display("[TB] FAIL mm_set got %0b exp 1", mismatch); else passCount++;
        checkCount++; if (modelState !== 2'd2) $display("[TB] FAIL mm_model got %0d exp 2", modelState); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b01) $display("[TB] FAIL mm_ij got %b exp 01", {dutI, dutJ}); else passCount++;
        repeat (2) @(negedge clk);
        checkCount++; if (mismatch !== 1'b1) $display("[TB] FAIL mm_sticky got %0b exp 1", mismatch); else passCount++;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checkCount++; if (mismatch !== 1'b0) $display("[TB] FAIL mm_clear got %0b exp 0", mismatch); else passCount++;
    endtask

    task automatic test_reset_mid_run();
        goalValid = 1'b1; goal = 2'd3;
        @(negedge clk);
        goalValid = 1'b0;
        @(negedge clk);
        checkCount++; if (modelState !== 2'd1) $display("[TB] FAIL mid_step1 got %0d exp 1", modelState); else passCount++;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL mid_done got %0b exp 0", done); else passCount++;
        checkCount++; if (modelState !== 2'd0) $display("[TB] FAIL mid_model got %0d exp 0", modelState); else passCount++;
        checkCount++; if ({dutI, dutJ} !== 2'b00) $display("[TB] FAIL mid_ij got %b exp 00", {dutI, dutJ}); else passCount++;
        checkCount++; if (goalReady !== 1'b1) $display("[TB] FAIL mid_ready got %0b exp 1", goalReady); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL mid_nodone got %0b exp 0", done); else passCount++;
        goalValid = 1'b1; goal = 2'd3;
        @(negedge clk);
        goalValid = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL mid_new_done got %0b exp 1", done); else passCount++;
        checkCount++; if (steps !== 2'd2) $display("[TB] FAIL mid_new_steps got %0d exp 2", steps); else passCount++;
        checkCount++; if (modelState !== 2'd3) $display("[TB] FAIL mid_new_model got %0d exp 3", modelState); else passCount++;
        checkCount++; if ({x, y} !== 2'b10) $display("[TB] FAIL mid_new_xy got %b exp 10", {x, y}); else passCount++;
        checkCount++; if (mismatch !== 1'b0) $display("[TB] FAIL mid_mismatch got %0b exp 0", mismatch); else passCount++;
    endtask

    // Scenario sequence and summary.
    initial begin
        checkCount = 0;
        passCount  = 0;
        rstn = 1'b0; goalValid = 1'b0; goal = 2'd0; forceXy = 1'b0;
        @(negedge clk);
        test_reset();
        test_goal_c();
        test_goal_a_from_c();
        test_goal_b();
        test_goal_same();
        test_mismatch();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
